// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_e;

    localparam logic [3:0] FETCH_MASK = 4'hF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on conflict the requester that did not win last time is chosen.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_grant,
    output req_id_e    grant_id,
    output logic       grant_vld
);

    always_comb begin
        grant_vld = |req;
        grant_id  = REQ_IF;
        case (req)
            2'b01:   grant_id = REQ_IF;
            2'b10:   grant_id = REQ_DM;
            2'b11:   grant_id = (last_grant == REQ_IF) ? REQ_DM : REQ_IF;
            default: grant_id = REQ_IF;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_request,
    input  logic [DataWidth-1:0] if_addr,
    output logic [DataWidth-1:0] if_rdata,
    output logic                 if_data_valid,
    input  logic                 dm_request,
    input  logic                 dm_we_re,
    input  logic [3:0]           dm_mask,
    input  logic [DataWidth-1:0] dm_addr,
    input  logic [DataWidth-1:0] dm_wdata,
    output logic [DataWidth-1:0] dm_rdata,
    output logic                 dm_data_valid,
    output logic                 mem_request,
    output logic                 mem_we_re,
    output logic [3:0]           mem_mask,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata,
    input  logic                 mem_data_valid,
    output logic                 stall,
    output logic                 timeout_err
);

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    req_id_e              r_last_grant;
    req_id_e              w_grant_id;
    logic                 w_grant_vld;
    logic                 w_busy;
    logic                 w_finish;
    logic                 w_timeout;
    logic                 r_mem_request;
    logic                 r_mem_we_re;
    logic [3:0]           r_mem_mask;
    logic [DataWidth-1:0] r_mem_addr;
    logic [DataWidth-1:0] r_mem_wdata;
    logic [DataWidth-1:0] r_if_rdata;
    logic [DataWidth-1:0] r_dm_rdata;

    rr_pick2 u_pick (
        .req        ({dm_request, if_request}),
        .last_grant (r_last_grant),
        .grant_id   (w_grant_id),
        .grant_vld  (w_grant_vld)
    );

    assign w_busy   = (r_state == BUSY_IF) || (r_state == BUSY_DM);
    assign w_finish = w_busy && (mem_data_valid || w_timeout);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] r_to_cnt;
    logic            r_to_flag;

    // Data arriving on the final watchdog cycle takes priority over the timeout.
    assign w_timeout = w_busy && !mem_data_valid && (r_to_cnt == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_to_cnt <= '0;
            end else if (w_busy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_finish) begin
                r_to_flag <= w_timeout;
            end
        end
    end

    assign timeout_err = (r_state == RESP) && r_to_flag;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_next = (w_grant_id == REQ_DM) ? BUSY_DM : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (w_finish) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // r_last_grant doubles as the owner of the transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= REQ_IF;
            r_mem_request <= 1'b0;
            r_mem_we_re   <= 1'b0;
            r_mem_mask    <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_rdata    <= '0;
            r_dm_rdata    <= '0;
        end else if ((r_state == IDLE) && w_grant_vld) begin
            r_mem_request <= 1'b1;
            r_last_grant  <= w_grant_id;
            if (w_grant_id == REQ_DM) begin
                r_mem_we_re <= dm_we_re;
                r_mem_mask  <= dm_mask;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else begin
                r_mem_we_re <= 1'b0;
                r_mem_mask  <= FETCH_MASK;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end
        end else if (w_finish) begin
            r_mem_request <= 1'b0;
            if (r_state == BUSY_IF) begin
                r_if_rdata <= mem_data_valid ? mem_rdata : '0;
            end else begin
                r_dm_rdata <= mem_data_valid ? mem_rdata : '0;
            end
        end
    end

    assign mem_request   = r_mem_request;
    assign mem_we_re     = r_mem_we_re;
    assign mem_mask      = r_mem_mask;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign if_rdata      = r_if_rdata;
    assign dm_rdata      = r_dm_rdata;
    assign if_data_valid = (r_state == RESP) && (r_last_grant == REQ_IF);
    assign dm_data_valid = (r_state == RESP) && (r_last_grant == REQ_DM);
    assign stall         = (if_request || dm_request) && (r_state != RESP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory issues and
// responses, a monitor checks them as the DUT presents them.
module tb_mem_port_arbiter;

    localparam int DW = 32;

    typedef struct {
        bit          dm;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct {
        bit          dm;
        logic [31:0] rdata;
        bit          to;
        int          lat;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_request = 1'b0;
    logic [DW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_data_valid;
    logic          dm_request = 1'b0;
    logic          dm_we_re = 1'b0;
    logic [3:0]    dm_mask = '0;
    logic [DW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_data_valid;
    logic          mem_request;
    logic          mem_we_re;
    logic [3:0]    mem_mask;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_data_valid = 1'b0;
    logic          stall;
    logic          timeout_err;

    int   errors = 0;
    int   checks = 0;
    int   mem_lat = 1;
    bit   spur = 1'b0;
    iss_t iss_q[$];
    rsp_t rsp_q[$];

    mem_port_arbiter #(
        .DataWidth     (DW),
        .TimeoutCycles (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_request     (if_request),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_data_valid  (if_data_valid),
        .dm_request     (dm_request),
        .dm_we_re       (dm_we_re),
        .dm_mask        (dm_mask),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata),
        .dm_data_valid  (dm_data_valid),
        .mem_request    (mem_request),
        .mem_we_re      (mem_we_re),
        .mem_mask       (mem_mask),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .stall          (stall),
        .timeout_err    (timeout_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: answers after mem_lat cycles of mem_request (0 = never).
    initial begin
        int mcnt;
        mcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_request) begin
                mcnt++;
                mem_data_valid = (mem_lat != 0) && (mcnt == mem_lat);
                mem_rdata      = memval(mem_addr);
            end else begin
                mcnt           = 0;
                mem_data_valid = spur;
                mem_rdata      = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int   cyc, rise_cyc;
        bit   prev_req, prev_dv, post_resp;
        iss_t cur;
        rsp_t r;
        cyc = 0; rise_cyc = 0; prev_req = 0; prev_dv = 0; post_resp = 0;
        cur = '{0, 1'b0, 4'h0, 32'h0, 32'h0};
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                prev_req = 0; prev_dv = 0; post_resp = 0;
                continue;
            end
            chk("stall", {31'b0, stall},
                {31'b0, (if_request | dm_request) & ~(if_data_valid | dm_data_valid)});
            if (mem_request && !prev_req) begin
                rise_cyc = cyc;
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got addr %h expected no issue", mem_addr);
                end else begin
                    cur = iss_q.pop_front();
                    chk("issue_owner", {31'b0, cur.dm}, {31'b0, cur.dm});
                end
            end
            if (mem_request) begin
                chk("mem_we_re", {31'b0, mem_we_re}, {31'b0, cur.we});
                chk("mem_mask", {28'b0, mem_mask}, {28'b0, cur.mask});
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (post_resp) begin
                chk("no_issue_after_resp", {31'b0, mem_request}, 32'd0);
                post_resp = 0;
            end
            if (if_data_valid || dm_data_valid) begin
                chk("single_valid", {31'b0, if_data_valid & dm_data_valid}, 32'd0);
                chk("valid_one_cycle", {31'b0, prev_dv}, 32'd0);
                chk("no_issue_in_resp", {31'b0, mem_request}, 32'd0);
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got if_dv=%0b dm_dv=%0b expected none",
                             if_data_valid, dm_data_valid);
                end else begin
                    r = rsp_q.pop_front();
                    chk("resp_owner", {31'b0, dm_data_valid}, {31'b0, r.dm});
                    chk(r.dm ? "dm_rdata" : "if_rdata", r.dm ? dm_rdata : if_rdata, r.rdata);
                    chk("timeout_err", {31'b0, timeout_err}, {31'b0, r.to});
                    chk("latency", 32'(cyc - rise_cyc), 32'(r.lat));
                end
                post_resp = 1;
                prev_dv   = 1;
            end else begin
                chk("timeout_err_idle", {31'b0, timeout_err}, 32'd0);
                prev_dv = 0;
            end
            prev_req = mem_request;
        end
    end

    task automatic wait_valid(input bit dm, input bit drop, output bit ok);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (drop && mem_request) begin
                if (dm) dm_request = 1'b0; else if_request = 1'b0;
            end
            if (dm ? dm_data_valid : if_data_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_valid: got no %s_data_valid within 200 cycles, expected one",
                     dm ? "dm" : "if");
        end
    endtask

    task automatic run_one(input bit dm, input logic we, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input bit drop);
        bit ok;
        mem_lat = lat;
        @(negedge clk);
        if (dm) begin
            dm_we_re = we; dm_mask = mask; dm_addr = addr; dm_wdata = wdata;
            dm_request = 1'b1;
        end else begin
            if_addr    = addr;
            if_request = 1'b1;
        end
        wait_valid(dm, drop, ok);
        if (dm) dm_request = 1'b0; else if_request = 1'b0;
    endtask

    initial begin
        bit ok_i, ok_d;
        #1;
        chk("rst_mem_request", {31'b0, mem_request}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_valids", {30'b0, if_data_valid, dm_data_valid}, 32'd0);
        chk("rst_stall_to", {30'b0, stall, timeout_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lone DM store, memory answers on the third request cycle.
        iss_q.push_back('{1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});
        rsp_q.push_back('{1, 32'h0100_FEFF, 0, 3});
        run_one(1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 3, 0);

        // Lone fetch; stale DM fields must not leak onto the memory bus.
        dm_we_re = 1'b1; dm_mask = 4'b0101; dm_wdata = 32'h1234_5678;
        iss_q.push_back('{0, 1'b0, 4'hF, 32'h40, 32'h0});
        rsp_q.push_back('{0, 32'h0050_0093, 0, 2});
        run_one(0, 1'b0, 4'h0, 32'h40, 32'h0, 2, 0);

        // Fetch request withdrawn mid-BUSY still completes.
        iss_q.push_back('{0, 1'b0, 4'hF, 32'h80, 32'h0});
        rsp_q.push_back('{0, 32'h0080_FF7F, 0, 3});
        run_one(0, 1'b0, 4'h0, 32'h80, 32'h0, 3, 1);

        // Stray memory strobe while idle.
        repeat (2) @(negedge clk);
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_quiet", {29'b0, mem_request, if_data_valid, dm_data_valid}, 32'd0);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        iss_q.push_back('{1, 1'b0, 4'hF, 32'h610, 32'h0BAD_F00D});
        rsp_q.push_back('{1, 32'h0, 1, 4});
        run_one(1, 1'b0, 4'hF, 32'h610, 32'h0BAD_F00D, 0, 0);
        iss_q.push_back('{1, 1'b0, 4'hF, 32'h614, 32'h0BAD_F00D});
        rsp_q.push_back('{1, 32'h0614_F9EB, 0, 4});
        run_one(1, 1'b0, 4'hF, 32'h614, 32'h0BAD_F00D, 4, 0);
`else
        iss_q.push_back('{1, 1'b0, 4'hF, 32'h600, 32'h0BAD_F00D});
        rsp_q.push_back('{1, 32'h0600_F9FF, 0, 8});
        run_one(1, 1'b0, 4'hF, 32'h600, 32'h0BAD_F00D, 8, 0);
`endif

        // Reset while a DM load is outstanding.
        mem_lat = 0;
        iss_q.push_back('{1, 1'b0, 4'hF, 32'h500, 32'h0});
        @(negedge clk);
        dm_we_re = 1'b0; dm_mask = 4'hF; dm_addr = 32'h500; dm_wdata = 32'h0;
        dm_request = 1'b1;
        for (int n = 0; n < 20 && !mem_request; n++) @(negedge clk);
        chk("busy_before_reset", {31'b0, mem_request}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        dm_request = 1'b0;
        #1;
        chk("mid_rst_mem_request", {31'b0, mem_request}, 32'd0);
        chk("mid_rst_mem_fields", {27'b0, mem_we_re, mem_mask}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
        chk("mid_rst_if_rdata", if_rdata, 32'd0);
        chk("mid_rst_dm_rdata", dm_rdata, 32'd0);
        chk("mid_rst_flags", {28'b0, if_data_valid, dm_data_valid, stall, timeout_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Both requesters held: DM first after reset, then strict alternation.
        mem_lat = 1;
        iss_q.push_back('{1, 1'b0, 4'b1100, 32'h300, 32'h0});
        iss_q.push_back('{0, 1'b0, 4'hF,    32'h200, 32'h0});
        iss_q.push_back('{1, 1'b0, 4'b1100, 32'h304, 32'h0});
        iss_q.push_back('{0, 1'b0, 4'hF,    32'h204, 32'h0});
        rsp_q.push_back('{1, 32'h0300_FCFF, 0, 1});
        rsp_q.push_back('{0, 32'h0200_FDFF, 0, 1});
        rsp_q.push_back('{1, 32'h0304_FCFB, 0, 1});
        rsp_q.push_back('{0, 32'h0204_FDFB, 0, 1});
        @(negedge clk);
        if_addr = 32'h200;
        dm_we_re = 1'b0; dm_mask = 4'b1100; dm_addr = 32'h300; dm_wdata = 32'h0;
        if_request = 1'b1;
        dm_request = 1'b1;
        fork
            begin
                wait_valid(0, 0, ok_i);
                if_addr = 32'h204;
                wait_valid(0, 0, ok_i);
                if_request = 1'b0;
            end
            begin
                wait_valid(1, 0, ok_d);
                dm_addr = 32'h304;
                wait_valid(1, 0, ok_d);
                dm_request = 1'b0;
            end
        join

        repeat (5) @(negedge clk);
        chk("iss_q_drained", iss_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
